// File: rtl/sram_bist_pkg.sv
// Shared types for the SRAM test vehicle: FSM state encoding and March C- element table.
// Each element is described by sweep direction, optional read-expect and optional write value.
package sram_bist_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
   } st_t;

   typedef struct packed {
      logic down;
      logic has_rd;
      logic rd_val;
      logic has_wr;
      logic wr_val;
   } elem_t;

   function automatic elem_t elem_cfg(st_t s);
      case (s)
         S_M0:    return '{down: 1'b0, has_rd: 1'b0, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b0};
         S_M1:    return '{down: 1'b0, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b1};
         S_M2:    return '{down: 1'b0, has_rd: 1'b1, rd_val: 1'b1, has_wr: 1'b1, wr_val: 1'b0};
         S_M3:    return '{down: 1'b1, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b1};
         S_M4:    return '{down: 1'b1, has_rd: 1'b1, rd_val: 1'b1, has_wr: 1'b1, wr_val: 1'b0};
         S_M5:    return '{down: 1'b0, has_rd: 1'b1, rd_val: 1'b0, has_wr: 1'b0, wr_val: 1'b0};
         default: return '0;
      endcase
   endfunction

   function automatic st_t next_elem(st_t s);
      case (s)
         S_M0:    return S_M1;
         S_M1:    return S_M2;
         S_M2:    return S_M3;
         S_M3:    return S_M4;
         S_M4:    return S_M5;
         S_M5:    return S_DRAIN;
         default: return S_IDLE;
      endcase
   endfunction

   function automatic int fbit_w(int dw);
      return (dw > 1) ? $clog2(dw) : 1;
   endfunction

endpackage

// File: rtl/sram_bist_if.sv
// Functional, BIST-control and fault-injection signals of the SRAM test vehicle.
// master = test controller / lab bench, slave = sram_bist.
interface sram_bist_if
   import sram_bist_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 2,
   parameter int CNT_WIDTH  = 8
);
   localparam int FB_W = fbit_w(DATA_WIDTH);

   logic                  cs;
   logic                  we;
   logic [DATA_WIDTH-1:0] DataIn;
   logic [ADDR_WIDTH-1:0] Address;
   logic [DATA_WIDTH-1:0] DataOut;
   logic                  bist_start;
   logic                  bist_busy;
   logic                  bist_done;
   logic                  bist_fail;
   logic [ADDR_WIDTH-1:0] fail_addr;
   logic [CNT_WIDTH-1:0]  fail_count;
   logic                  fault_en;
   logic [ADDR_WIDTH-1:0] fault_addr;
   logic [FB_W-1:0]       fault_bit;
   logic                  fault_val;

   modport master (
      output cs, we, DataIn, Address, bist_start, fault_en, fault_addr, fault_bit, fault_val,
      input  DataOut, bist_busy, bist_done, bist_fail, fail_addr, fail_count
   );

   modport slave (
      input  cs, we, DataIn, Address, bist_start, fault_en, fault_addr, fault_bit, fault_val,
      output DataOut, bist_busy, bist_done, bist_fail, fail_addr, fail_count
   );

endinterface

// File: rtl/sram_core.sv
// Plain storage array: synchronous write, combinational read at the shared address.
// No reset on the contents; callers gate out-of-range writes.
module sram_core #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 2,
   parameter int DATA_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

   always_ff @(posedge clk) begin
      if (wen) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/sram_bist.sv
// Single-port SRAM with March C- BIST and a run-time stuck-at fault injector on the read path.
// Read latency 1 cycle; BIST takes 10*DATA_DEPTH+2 cycles from the start edge, no backpressure.
module sram_bist
   import sram_bist_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 2,
   parameter int DATA_DEPTH = 16,
   parameter int CNT_WIDTH  = 8
) (
   input logic        clk,
   input logic        rst,
   sram_bist_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DATA_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  C_ONE = CNT_WIDTH'(1);

   st_t                   state, state_nxt;
   logic [ADDR_WIDTH-1:0] baddr, baddr_nxt;
   logic                  phase, phase_nxt;
   elem_t                 cfg, nxt_cfg;

   logic                  func_mode;
   logic                  addr_ok;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  bist_rd;
   logic [DATA_WIDTH-1:0] bist_exp;
   logic [ADDR_WIDTH-1:0] end_addr;
   logic                  two_op;

   logic [DATA_WIDTH-1:0] dout_q;
   logic                  cmp_vld;
   logic [DATA_WIDTH-1:0] cmp_exp;
   logic [ADDR_WIDTH-1:0] cmp_addr;
   logic                  fail_q;
   logic [ADDR_WIDTH-1:0] fail_addr_q;
   logic [CNT_WIDTH-1:0]  fail_cnt_q;

   assign func_mode = (state == S_IDLE) || (state == S_DONE);
   assign addr_ok   = int'(bus.Address) < DATA_DEPTH;
   assign cfg       = elem_cfg(state);
   assign nxt_cfg   = elem_cfg(next_elem(state));
   assign end_addr  = cfg.down ? '0 : LAST;
   assign two_op    = cfg.has_rd && cfg.has_wr;

   sram_core #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DATA_DEPTH (DATA_DEPTH)
   ) u_core (
      .clk   (clk),
      .wen   (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   // Fault is applied to whatever address is being read this cycle, functional or BIST.
   always_comb begin
      rd_word = mem_rdata;
      if (bus.fault_en && (mem_addr == bus.fault_addr)) rd_word[bus.fault_bit] = bus.fault_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         baddr <= '0;
         phase <= 1'b0;
      end else begin
         state <= state_nxt;
         baddr <= baddr_nxt;
         phase <= phase_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      baddr_nxt = baddr;
      phase_nxt = phase;
      mem_we    = 1'b0;
      mem_addr  = bus.Address;
      mem_wdata = bus.DataIn;
      bist_rd   = 1'b0;
      bist_exp  = '0;
      case (state)
         S_IDLE, S_DONE: begin
            mem_we = !bus.cs && !bus.we && addr_ok;
            if (bus.bist_start) begin
               state_nxt = S_M0;
               baddr_nxt = '0;
               phase_nxt = 1'b0;
            end
         end
         S_DRAIN: state_nxt = S_DONE;
         default: begin
            mem_addr = baddr;
            if (cfg.has_rd && !phase) begin
               bist_rd  = 1'b1;
               bist_exp = {DATA_WIDTH{cfg.rd_val}};
            end else begin
               mem_we    = 1'b1;
               mem_wdata = {DATA_WIDTH{cfg.wr_val}};
            end
            if (two_op) phase_nxt = !phase;
            // Address advances only once every operation of the element is done at it.
            if (!two_op || phase) begin
               if (baddr == end_addr) begin
                  state_nxt = next_elem(state);
                  baddr_nxt = nxt_cfg.down ? LAST : '0;
               end else begin
                  baddr_nxt = cfg.down ? baddr - A_ONE : baddr + A_ONE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q      <= '0;
         cmp_vld     <= 1'b0;
         cmp_exp     <= '0;
         cmp_addr    <= '0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_cnt_q  <= '0;
      end else begin
         cmp_vld  <= bist_rd;
         cmp_exp  <= bist_exp;
         cmp_addr <= baddr;
         if (bist_rd) begin
            dout_q <= rd_word;
         end else if (func_mode && !bus.cs && bus.we) begin
            dout_q <= addr_ok ? rd_word : '0;
         end
         if (func_mode && bus.bist_start) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
         end else if (cmp_vld && (dout_q != cmp_exp)) begin
            fail_q <= 1'b1;
            if (!fail_q) fail_addr_q <= cmp_addr;
            if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + C_ONE;
         end
      end
   end

   assign bus.DataOut    = dout_q;
   assign bus.bist_busy  = !func_mode;
   assign bus.bist_done  = (state == S_DONE);
   assign bus.bist_fail  = fail_q;
   assign bus.fail_addr  = fail_addr_q;
   assign bus.fail_count = fail_cnt_q;

endmodule

// File: tb/tb_sram_bist.sv
// Directed bench for sram_bist: default 2x16 instance plus an 8x12 instance for the generic case.
module tb_sram_bist;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   sram_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(2), .CNT_WIDTH(8)) a_if ();
   sram_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .CNT_WIDTH(8)) b_if ();

   sram_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(2), .DATA_DEPTH(16), .CNT_WIDTH(8)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (a_if.slave)
   );

   sram_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DATA_DEPTH(12), .CNT_WIDTH(8)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (b_if.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done_a(output int n);
      n = 0;
      while (a_if.bist_done !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
   endtask

   task automatic start_a();
      a_if.bist_start = 1'b1;
      tick();
      a_if.bist_start = 1'b0;
   endtask

   task automatic test_reset();
      rst_a = 1'b1;
      rst_b = 1'b1;
      tick();
      tick();
      tests++; if (a_if.DataOut !== 2'b00) begin fails++; $display("FAIL rst_dataout: got %0h want 0", a_if.DataOut); end
      tests++; if (a_if.bist_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", a_if.bist_busy); end
      tests++; if (a_if.bist_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %0b want 0", a_if.bist_done); end
      tests++; if (a_if.bist_fail !== 1'b0) begin fails++; $display("FAIL rst_fail: got %0b want 0", a_if.bist_fail); end
      tests++; if (a_if.fail_addr !== 4'd0) begin fails++; $display("FAIL rst_fail_addr: got %0d want 0", a_if.fail_addr); end
      tests++; if (a_if.fail_count !== 8'd0) begin fails++; $display("FAIL rst_fail_count: got %0d want 0", a_if.fail_count); end
      rst_a = 1'b0;
      rst_b = 1'b0;
   endtask

   task automatic test_func_rw();
      a_if.cs = 1'b0; a_if.we = 1'b0; a_if.Address = 4'd3; a_if.DataIn = 2'b01;
      tick();
      a_if.Address = 4'd5; a_if.DataIn = 2'b10;
      tick();
      a_if.we = 1'b1; a_if.Address = 4'd3;
      tick();
      tests++; if (a_if.DataOut !== 2'b01) begin fails++; $display("FAIL func_rd3: got %0h want 1", a_if.DataOut); end
      a_if.Address = 4'd5;
      tick();
      tests++; if (a_if.DataOut !== 2'b10) begin fails++; $display("FAIL func_rd5: got %0h want 2", a_if.DataOut); end
      a_if.cs = 1'b1; a_if.Address = 4'd3;
      tick();
      tests++; if (a_if.DataOut !== 2'b10) begin fails++; $display("FAIL func_cs_hold: got %0h want 2", a_if.DataOut); end
   endtask

   task automatic test_bist_clean();
      int n;
      // Functional read and start in the same cycle: the read completes, BIST begins next.
      a_if.cs = 1'b0; a_if.we = 1'b1; a_if.Address = 4'd3; a_if.bist_start = 1'b1;
      tick();
      a_if.cs = 1'b1; a_if.bist_start = 1'b0;
      tests++; if (a_if.DataOut !== 2'b01) begin fails++; $display("FAIL clean_simul_read: got %0h want 1", a_if.DataOut); end
      tests++; if (a_if.bist_busy !== 1'b1) begin fails++; $display("FAIL clean_busy: got %0b want 1", a_if.bist_busy); end
      wait_done_a(n);
      n++;
      tests++; if (n !== 162) begin fails++; $display("FAIL clean_cycles: got %0d want 162", n); end
      tests++; if (a_if.bist_busy !== 1'b0) begin fails++; $display("FAIL clean_busy_end: got %0b want 0", a_if.bist_busy); end
      tests++; if (a_if.bist_fail !== 1'b0) begin fails++; $display("FAIL clean_fail: got %0b want 0", a_if.bist_fail); end
      tests++; if (a_if.fail_count !== 8'd0) begin fails++; $display("FAIL clean_count: got %0d want 0", a_if.fail_count); end
   endtask

   task automatic test_sa1();
      int n;
      a_if.fault_en = 1'b1; a_if.fault_addr = 4'd5; a_if.fault_bit = 1'b1; a_if.fault_val = 1'b1;
      start_a();
      wait_done_a(n);
      n++;
      tests++; if (n !== 162) begin fails++; $display("FAIL sa1_cycles: got %0d want 162", n); end
      tests++; if (a_if.bist_fail !== 1'b1) begin fails++; $display("FAIL sa1_fail: got %0b want 1", a_if.bist_fail); end
      tests++; if (a_if.fail_addr !== 4'd5) begin fails++; $display("FAIL sa1_addr: got %0d want 5", a_if.fail_addr); end
      tests++; if (a_if.fail_count !== 8'd3) begin fails++; $display("FAIL sa1_count: got %0d want 3", a_if.fail_count); end
   endtask

   task automatic test_restart();
      int n;
      a_if.fault_en = 1'b0;
      start_a();
      tests++; if (a_if.bist_done !== 1'b0) begin fails++; $display("FAIL restart_done_clr: got %0b want 0", a_if.bist_done); end
      tests++; if (a_if.bist_fail !== 1'b0) begin fails++; $display("FAIL restart_fail_clr: got %0b want 0", a_if.bist_fail); end
      tests++; if (a_if.fail_count !== 8'd0) begin fails++; $display("FAIL restart_count_clr: got %0d want 0", a_if.fail_count); end
      tests++; if (a_if.fail_addr !== 4'd0) begin fails++; $display("FAIL restart_addr_clr: got %0d want 0", a_if.fail_addr); end
      wait_done_a(n);
      tests++; if (a_if.bist_fail !== 1'b0) begin fails++; $display("FAIL restart_fail: got %0b want 0", a_if.bist_fail); end
   endtask

   task automatic test_sa0();
      int n;
      a_if.fault_en = 1'b1; a_if.fault_addr = 4'd0; a_if.fault_bit = 1'b0; a_if.fault_val = 1'b0;
      start_a();
      wait_done_a(n);
      tests++; if (a_if.bist_fail !== 1'b1) begin fails++; $display("FAIL sa0_fail: got %0b want 1", a_if.bist_fail); end
      tests++; if (a_if.fail_addr !== 4'd0) begin fails++; $display("FAIL sa0_addr: got %0d want 0", a_if.fail_addr); end
      tests++; if (a_if.fail_count !== 8'd2) begin fails++; $display("FAIL sa0_count: got %0d want 2", a_if.fail_count); end
      a_if.cs = 1'b0; a_if.we = 1'b0; a_if.Address = 4'd0; a_if.DataIn = 2'b11;
      tick();
      a_if.we = 1'b1;
      tick();
      tests++; if (a_if.DataOut !== 2'b10) begin fails++; $display("FAIL sa0_func_rd: got %0h want 2", a_if.DataOut); end
      a_if.fault_en = 1'b0;
      tick();
      a_if.cs = 1'b1;
      tests++; if (a_if.DataOut !== 2'b11) begin fails++; $display("FAIL sa0_nofault_rd: got %0h want 3", a_if.DataOut); end
   endtask

   task automatic test_rst_mid();
      int n;
      a_if.fault_en = 1'b1; a_if.fault_addr = 4'd5; a_if.fault_bit = 1'b1; a_if.fault_val = 1'b1;
      start_a();
      // 90 cycles after start lands inside M3 (which spans start+81..start+112).
      for (int i = 0; i < 89; i++) tick();
      tests++; if (a_if.bist_fail !== 1'b1) begin fails++; $display("FAIL mid_pre_fail: got %0b want 1", a_if.bist_fail); end
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      tests++; if (a_if.bist_busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %0b want 0", a_if.bist_busy); end
      tests++; if (a_if.bist_done !== 1'b0) begin fails++; $display("FAIL mid_done: got %0b want 0", a_if.bist_done); end
      tests++; if (a_if.bist_fail !== 1'b0) begin fails++; $display("FAIL mid_fail: got %0b want 0", a_if.bist_fail); end
      tests++; if (a_if.fail_addr !== 4'd0) begin fails++; $display("FAIL mid_addr: got %0d want 0", a_if.fail_addr); end
      tests++; if (a_if.fail_count !== 8'd0) begin fails++; $display("FAIL mid_count: got %0d want 0", a_if.fail_count); end
      tests++; if (a_if.DataOut !== 2'b00) begin fails++; $display("FAIL mid_dataout: got %0h want 0", a_if.DataOut); end
      a_if.fault_en = 1'b0;
      start_a();
      wait_done_a(n);
      n++;
      tests++; if (n !== 162) begin fails++; $display("FAIL mid_rerun_cycles: got %0d want 162", n); end
      tests++; if (a_if.fail_count !== 8'd0) begin fails++; $display("FAIL mid_rerun_count: got %0d want 0", a_if.fail_count); end
   endtask

   task automatic test_generic();
      int n;
      b_if.cs = 1'b0; b_if.we = 1'b0; b_if.Address = 4'd13; b_if.DataIn = 8'hA5;
      tick();
      b_if.Address = 4'd2; b_if.DataIn = 8'h3C;
      tick();
      b_if.we = 1'b1;
      tick();
      tests++; if (b_if.DataOut !== 8'h3C) begin fails++; $display("FAIL gen_rd2: got %0h want 3c", b_if.DataOut); end
      b_if.Address = 4'd13;
      tick();
      b_if.cs = 1'b1;
      tests++; if (b_if.DataOut !== 8'h00) begin fails++; $display("FAIL gen_rd13: got %0h want 0", b_if.DataOut); end
      b_if.fault_en = 1'b1; b_if.fault_addr = 4'd11; b_if.fault_bit = 3'd7; b_if.fault_val = 1'b1;
      b_if.bist_start = 1'b1;
      tick();
      b_if.bist_start = 1'b0;
      n = 0;
      while (b_if.bist_done !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      n++;
      tests++; if (n !== 122) begin fails++; $display("FAIL gen_cycles: got %0d want 122", n); end
      tests++; if (b_if.bist_fail !== 1'b1) begin fails++; $display("FAIL gen_fail: got %0b want 1", b_if.bist_fail); end
      tests++; if (b_if.fail_addr !== 4'd11) begin fails++; $display("FAIL gen_addr: got %0d want 11", b_if.fail_addr); end
      tests++; if (b_if.fail_count !== 8'd3) begin fails++; $display("FAIL gen_count: got %0d want 3", b_if.fail_count); end
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      a_if.cs = 1'b1; a_if.we = 1'b1; a_if.DataIn = '0; a_if.Address = '0; a_if.bist_start = 1'b0;
      a_if.fault_en = 1'b0; a_if.fault_addr = '0; a_if.fault_bit = '0; a_if.fault_val = 1'b0;
      b_if.cs = 1'b1; b_if.we = 1'b1; b_if.DataIn = '0; b_if.Address = '0; b_if.bist_start = 1'b0;
      b_if.fault_en = 1'b0; b_if.fault_addr = '0; b_if.fault_bit = '0; b_if.fault_val = 1'b0;
      test_reset();
      test_func_rw();
      test_bist_clean();
      test_sa1();
      test_restart();
      test_sa0();
      test_rst_mid();
      test_generic();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
